// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the divided-clock period meter.
package clkdiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HIGH,
    LOW,
    DONE
  } meter_state_e;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned SAT_DEF   = (2 ** CNT_W_DEF) - 1;

endpackage

// File: rtl/clkdiv_period_meter_edge_detect.sv
// Edge detector for the measured signal; CLKDIV_METER_SYNC_EN inserts a
// 2-flop synchronizer ahead of the sig_d register for asynchronous sources.
module clkdiv_edge_detect
  import clkdiv_pkg::*;
(
  input  logic clk_in,
  input  logic nrst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic sig_s;
  logic sig_d;

`ifdef CLKDIV_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_in) begin
    if (!nrst) sync_q <= '0;
    else       sync_q <= {sync_q[0], sig_in};
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = sig_in;
`endif

  always_ff @(posedge clk_in) begin
    if (!nrst) sig_d <= 1'b0;
    else       sig_d <= sig_s;
  end

  assign rise = sig_s & ~sig_d;
  assign fall = ~sig_s & sig_d;

endmodule

// File: rtl/clkdiv_period_meter.sv
// Measures high phase and period of one cycle of sig_in in clk_in cycles.
// Optional macro CLKDIV_METER_SYNC_EN adds an input synchronizer (see edge detect).
//
// state | meaning
// IDLE  | waiting for start; results from the last measurement held
// ARM   | waiting for the first rising edge, bounded by ARM_TIMEOUT
// HIGH  | counting the high phase
// LOW   | counting the low phase until the next rising edge
// DONE  | result_valid; waits for ready (to IDLE) or start (to ARM)
module clkdiv_period_meter
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned ARM_TIMEOUT = SAT_DEF
) (
  input  logic             clk_in,
  input  logic             nrst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam logic [CNT_W-1:0] SAT      = '1;
  localparam logic [CNT_W-1:0] ARM_LOAD = CNT_W'(ARM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  meter_state_e     state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] arm_timer, arm_timer_nx;
  logic [CNT_W-1:0] high_tmp, high_tmp_nx;
  logic [CNT_W-1:0] high_nx, period_nx;
  logic             overflow_nx;
  logic             rise, fall;

  clkdiv_edge_detect u_edge (
    .clk_in (clk_in),
    .nrst   (nrst),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk_in) begin
    if (!nrst) begin
      state      <= IDLE;
      cnt        <= '0;
      arm_timer  <= '0;
      high_tmp   <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      arm_timer  <= arm_timer_nx;
      high_tmp   <= high_tmp_nx;
      high_cnt   <= high_nx;
      period_cnt <= period_nx;
      overflow   <= overflow_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    arm_timer_nx = arm_timer;
    high_tmp_nx  = high_tmp;
    high_nx      = high_cnt;
    period_nx    = period_cnt;
    overflow_nx  = overflow;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx     = ARM;
          arm_timer_nx = ARM_LOAD;
        end
      end
      ARM: begin
        if (rise) begin
          state_nx = HIGH;
          cnt_nx   = CNT_ONE;
        end else if (arm_timer == '0) begin
          state_nx    = DONE;
          overflow_nx = 1'b1;
          high_nx     = '0;
          period_nx   = '0;
        end else begin
          arm_timer_nx = arm_timer - 1'b1;
        end
      end
      HIGH: begin
        cnt_nx = cnt + 1'b1;
        // A high phase of SAT cycles leaves no room for the period, even if
        // the fall arrives on this very cycle, so it is reported as overflow.
        if (cnt == SAT) begin
          state_nx    = DONE;
          overflow_nx = 1'b1;
          high_nx     = SAT;
          period_nx   = SAT;
        end else if (fall) begin
          state_nx    = LOW;
          high_tmp_nx = cnt;
        end
      end
      LOW: begin
        cnt_nx = cnt + 1'b1;
        if (rise) begin
          state_nx    = DONE;
          overflow_nx = 1'b0;
          high_nx     = high_tmp;
          period_nx   = cnt;
        end else if (cnt == SAT) begin
          state_nx    = DONE;
          overflow_nx = 1'b1;
          high_nx     = high_tmp;
          period_nx   = SAT;
        end
      end
      DONE: begin
        if (start) begin
          state_nx     = ARM;
          arm_timer_nx = ARM_LOAD;
        end else if (result_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy         = (state == ARM) || (state == HIGH) || (state == LOW);
  assign result_valid = (state == DONE);

endmodule

// File: tb/tb_clkdiv_period_meter.sv
// Bench for clkdiv_period_meter: two instances (CNT_W=8/timeout 20 and
// CNT_W=4/timeout 15) measure the same waveform against an edge-index model.
module tb_clkdiv_period_meter;

`ifdef CLKDIV_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk_in = 1'b0;
  logic       nrst, sig_in, start, result_ready;
  logic       busy_a, ovf_a, valid_a, busy_b, ovf_b, valid_b;
  logic [7:0] high_a, period_a;
  logic [3:0] high_b, period_b;

  int errors = 0;
  int checks = 0;
  int w [0:127];
  int n_w;

  always #5 clk_in = ~clk_in;

  clkdiv_period_meter #(.CNT_W(8), .ARM_TIMEOUT(20)) u_dut_a (
    .clk_in(clk_in), .nrst(nrst), .sig_in(sig_in), .start(start), .busy(busy_a),
    .high_cnt(high_a), .period_cnt(period_a), .overflow(ovf_a),
    .result_valid(valid_a), .result_ready(result_ready)
  );

  clkdiv_period_meter #(.CNT_W(4), .ARM_TIMEOUT(15)) u_dut_b (
    .clk_in(clk_in), .nrst(nrst), .sig_in(sig_in), .start(start), .busy(busy_b),
    .high_cnt(high_b), .period_cnt(period_b), .overflow(ovf_b),
    .result_valid(valid_b), .result_ready(result_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waveform value sampled at edge k (edge 0 samples start); held before/after.
  function automatic int wv(input int k);
    if (k < 0) return w[0];
    if (k >= n_w) return w[n_w-1];
    return w[k];
  endfunction

  function automatic bit rise_at(input int e);
    return (wv(e - LAT) == 1) && (wv(e - LAT - 1) == 0);
  endfunction

  function automatic bit fall_at(input int e);
    return (wv(e - LAT) == 0) && (wv(e - LAT - 1) == 1);
  endfunction

  // Expected result and the edge index after which result_valid is seen.
  function automatic void model(input int cw, input int tmo,
                                output int hi, output int per, output int ovf, output int d);
    int sat, r1, f;
    sat = (1 << cw) - 1;
    r1 = -1;
    for (int e = 1; e <= tmo; e++) if (r1 < 0 && rise_at(e)) r1 = e;
    if (r1 < 0) begin
      hi = 0; per = 0; ovf = 1; d = tmo;
      return;
    end
    f = -1;
    for (int e = r1 + 1; e < r1 + sat; e++) if (f < 0 && fall_at(e)) f = e;
    if (f < 0) begin
      hi = sat; per = sat; ovf = 1; d = r1 + sat;
      return;
    end
    for (int e = f + 1; e <= r1 + sat; e++) begin
      if (rise_at(e)) begin
        hi = f - r1; per = e - r1; ovf = 0; d = e;
        return;
      end
    end
    hi = f - r1; per = sat; ovf = 1; d = r1 + sat;
  endfunction

  task automatic run_meas(input string tag, input bit rdy, input int restart_e);
    int ha, pa, oa, da, hb, pb, ob, db;
    int first_a, first_b, vc_a, vc_b;
    model(8, 20, ha, pa, oa, da);
    model(4, 15, hb, pb, ob, db);
    first_a = -1; first_b = -1; vc_a = 0; vc_b = 0;
    sig_in = w[0][0];
    start = 1'b0;
    result_ready = rdy;
    repeat (3) begin @(posedge clk_in); #1; end
    for (int e = 0; e < n_w; e++) begin
      sig_in = w[e][0];
      start = (e == 0) || (e == restart_e);
      @(posedge clk_in); #1;
      start = 1'b0;
      if (valid_a) begin
        if (first_a < 0) first_a = e;
        vc_a++;
        chk({tag, ".a.hold_high"}, high_a, ha);
        chk({tag, ".a.hold_period"}, period_a, pa);
      end
      if (valid_b) begin
        if (first_b < 0) first_b = e;
        vc_b++;
        chk({tag, ".b.hold_high"}, high_b, hb);
        chk({tag, ".b.hold_period"}, period_b, pb);
      end
    end
    chk({tag, ".a.latency"}, first_a, da);
    chk({tag, ".a.high"}, high_a, ha);
    chk({tag, ".a.period"}, period_a, pa);
    chk({tag, ".a.overflow"}, ovf_a, oa);
    chk({tag, ".a.valid_cycles"}, vc_a, rdy ? 1 : n_w - da);
    chk({tag, ".b.latency"}, first_b, db);
    chk({tag, ".b.high"}, high_b, hb);
    chk({tag, ".b.period"}, period_b, pb);
    chk({tag, ".b.overflow"}, ovf_b, ob);
    chk({tag, ".b.valid_cycles"}, vc_b, rdy ? 1 : n_w - db);
  endtask

  task automatic release_result(input string tag);
    result_ready = 1'b1;
    @(posedge clk_in); #1;
    result_ready = 1'b0;
    chk({tag, ".release.a.valid"}, valid_a, 0);
    chk({tag, ".release.b.valid"}, valid_b, 0);
    chk({tag, ".release.a.busy"}, busy_a, 0);
    chk({tag, ".release.b.busy"}, busy_b, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int hi, lo, ph;
    nrst = 1'b0; sig_in = 1'b0; start = 1'b0; result_ready = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 nrst = 1'b1;
    chk("reset.a.busy", busy_a, 0);
    chk("reset.a.valid", valid_a, 0);
    chk("reset.a.high", high_a, 0);
    chk("reset.a.period", period_a, 0);
    chk("reset.a.overflow", ovf_a, 0);
    chk("reset.b.busy", busy_b, 0);
    chk("reset.b.valid", valid_b, 0);

    // 4 high / 4 low, ready held high
    n_w = 30;
    for (int e = 0; e < n_w; e++) w[e] = (e >= 2) ? int'(((e - 2) % 8) < 4) : 0;
    run_meas("sq44", 1'b1, -1);

    // Reset while a measurement is in its high phase
    sig_in = 1'b0;
    repeat (3) begin @(posedge clk_in); #1; end
    start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    sig_in = 1'b1;
    repeat (3 + LAT) begin @(posedge clk_in); #1; end
    chk("rst_mid.a.busy_before", busy_a, 1);
    nrst = 1'b0;
    @(posedge clk_in); #1;
    nrst = 1'b1;
    chk("rst_mid.a.busy", busy_a, 0);
    chk("rst_mid.a.valid", valid_a, 0);
    chk("rst_mid.a.high", high_a, 0);
    chk("rst_mid.a.period", period_a, 0);
    chk("rst_mid.b.busy", busy_b, 0);
    chk("rst_mid.b.period", period_b, 0);

    // 1 high / 2 low, ready low well beyond 10 cycles
    n_w = 16;
    for (int e = 0; e < n_w; e++) w[e] = (e >= 2) ? int'(((e - 2) % 3) == 0) : 0;
    run_meas("sq12", 1'b0, -1);
    release_result("sq12");

    // sig_in stuck low: arm timeout
    n_w = 30;
    for (int e = 0; e < n_w; e++) w[e] = 0;
    run_meas("stuck0", 1'b0, -1);
    release_result("stuck0");

    // sig_in stuck high at start: waits for a rise, then times out
    for (int e = 0; e < n_w; e++) w[e] = 1;
    run_meas("stuck1", 1'b0, -1);
    release_result("stuck1");

    // Long high phase: saturates the 4-bit instance, measured by the 8-bit one
    n_w = 60;
    for (int e = 0; e < n_w; e++) w[e] = ((e >= 2 && e < 32) || e >= 37) ? 1 : 0;
    run_meas("sat", 1'b0, -1);
    start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    chk("restart_done.a.valid", valid_a, 0);
    chk("restart_done.a.busy", busy_a, 1);
    chk("restart_done.b.valid", valid_b, 0);
    chk("restart_done.b.busy", busy_b, 1);
    repeat (25) begin @(posedge clk_in); #1; end
    chk("restart_done.a.valid_after", valid_a, 1);
    chk("restart_done.a.overflow", ovf_a, 1);
    chk("restart_done.a.high", high_a, 0);
    chk("restart_done.b.overflow", ovf_b, 1);
    chk("restart_done.b.period", period_b, 0);
    release_result("restart_done");

    // start during measurement is ignored
    n_w = 30;
    for (int e = 0; e < n_w; e++) w[e] = (e >= 2) ? int'(((e - 2) % 8) < 4) : 0;
    run_meas("restart_busy", 1'b0, 4);
    release_result("restart_busy");

    // Randomized square waves
    for (int it = 0; it < 8; it++) begin
      hi = int'($urandom_range(6, 1));
      lo = int'($urandom_range(6, 1));
      ph = int'($urandom_range(hi + lo - 1, 0));
      n_w = 50;
      for (int e = 0; e < n_w; e++) w[e] = int'(((e + ph) % (hi + lo)) < hi);
      run_meas($sformatf("rand%0d_h%0d_l%0d", it, hi, lo), it[0], -1);
      release_result($sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
